// File: rtl/sequencer_xix_timing_pkg.sv
// Shared types and constants for the IX/IY sequencer timing block.
package sequencer_xix_timing_pkg;

   localparam int unsigned XPT_W   = 5;
   localparam int unsigned XPT_MAX = 31;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned MODE_W  = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_M1   = 2'd0,
      MODE_CMR  = 2'd1,
      MODE_EXEC = 2'd2
   } mode_e;

   // Decoder enable: a prefix is active, not in the DDCB/FDCB path, and executing.
   function automatic logic dec_enable_f(input logic xix, input logic xiy,
                                         input logic xix4, input mode_e mode);
      return (xix | xiy) & ~xix4 & (mode == MODE_EXEC);
   endfunction

endpackage

// File: rtl/sequencer_xix_timing_if.sv
// Strobe and status bundle between the bus/decoder side and the sequencer.
interface sequencer_xix_timing_if;
   import sequencer_xix_timing_pkg::*;

   logic                Bus_Ready;
   logic [DATA_W-1:0]   Bus_Data;
   logic                Set_XIX;
   logic                Set_XIY;
   logic                PR_Reset_XPT;
   logic                P2_Set_CM1;
   logic                P2_Set_CMR;
   logic                P2_Reset_XIX;
   logic                P2_Reset_XIY;
   logic                P2_Set_XIX4_0;
   logic                P2_Set_XIY4_0;
   logic                Pa_Ophd;

   logic                Phase2;
   logic [XPT_W-1:0]    XPT;
   logic [XPT_W-1:0]    notXPT;
   logic [DATA_W-1:0]   Source;
   logic [DATA_W-1:0]   notSource;
   logic                Dec_Enable;
   logic                is_Y;
   logic                In_XIX4;
   logic [MODE_W-1:0]   Mode;

   modport master (
      output Bus_Ready, Bus_Data, Set_XIX, Set_XIY, PR_Reset_XPT,
             P2_Set_CM1, P2_Set_CMR, P2_Reset_XIX, P2_Reset_XIY,
             P2_Set_XIX4_0, P2_Set_XIY4_0, Pa_Ophd,
      input  Phase2, XPT, notXPT, Source, notSource, Dec_Enable, is_Y,
             In_XIX4, Mode
   );

   modport slave (
      input  Bus_Ready, Bus_Data, Set_XIX, Set_XIY, PR_Reset_XPT,
             P2_Set_CM1, P2_Set_CMR, P2_Reset_XIX, P2_Reset_XIY,
             P2_Set_XIX4_0, P2_Set_XIY4_0, Pa_Ophd,
      output Phase2, XPT, notXPT, Source, notSource, Dec_Enable, is_Y,
             In_XIX4, Mode
   );

endinterface

// File: rtl/sequencer_step_counter.sv
// Half-step phase toggle and saturating machine-step counter with stall and restart.
module sequencer_step_counter
   import sequencer_xix_timing_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             i_ready,
   input  logic             i_clr,
   output logic             o_phase2,
   output logic [XPT_W-1:0] o_xpt
);

   logic             r_phase2;
   logic [XPT_W-1:0] r_xpt;

   // Advance phase every ready clock; step on second half, hold at terminal step.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_phase2 <= 1'b0;
         r_xpt    <= '0;
      end else if (i_ready) begin
         if (i_clr) begin
            r_phase2 <= 1'b0;
            r_xpt    <= '0;
         end else begin
            r_phase2 <= ~r_phase2;
            if (r_phase2 && (r_xpt != XPT_W'(XPT_MAX)))
               r_xpt <= r_xpt + XPT_W'(1);
         end
      end
   end

   assign o_phase2 = r_phase2;
   assign o_xpt    = r_xpt;

endmodule

// File: rtl/sequencer_xix_timing.sv
// Step/phase, cycle-mode and index-prefix state feeding the DD/FD decoder.
module sequencer_xix_timing
   import sequencer_xix_timing_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   sequencer_xix_timing_if.slave  bus
);

   logic              w_phase2;
   logic [XPT_W-1:0]  w_xpt;
   logic              w_p2;
   logic              w_fetch;
   mode_e             w_mode_nxt;
   logic              w_xix_nxt;
   logic              w_xiy_nxt;
   logic              w_xix4_nxt;

   mode_e             r_mode;
   logic              r_xix;
   logic              r_xiy;
   logic              r_xix4;
   logic              r_armed;
   logic [DATA_W-1:0] r_source;
   logic              r_dec_en;

   sequencer_step_counter u_step (
      .clock    (clock),
      .reset    (reset),
      .i_ready  (bus.Bus_Ready),
      .i_clr    (bus.PR_Reset_XPT),
      .o_phase2 (w_phase2),
      .o_xpt    (w_xpt)
   );

   // Second-half strobe window and end of the opcode fetch.
   assign w_p2    = bus.Bus_Ready & w_phase2;
   assign w_fetch = w_p2 & (r_mode == MODE_M1) & (w_xpt == XPT_W'(1));

   // Cycle-mode transitions; CM1 outranks CMR.
   always_comb begin
      w_mode_nxt = r_mode;
      unique case (r_mode)
         MODE_M1:   if (w_fetch) w_mode_nxt = MODE_EXEC;
         MODE_EXEC: begin
            if (w_p2 && bus.P2_Set_CM1)      w_mode_nxt = MODE_M1;
            else if (w_p2 && bus.P2_Set_CMR) w_mode_nxt = MODE_CMR;
         end
         MODE_CMR:  if (w_p2 && bus.P2_Set_CM1) w_mode_nxt = MODE_M1;
         default:   w_mode_nxt = MODE_M1;
      endcase
   end

   // Prefix flags: sub-state entry, then clears, then prefix sets (last prefix wins).
   always_comb begin
      w_xix_nxt  = r_xix;
      w_xiy_nxt  = r_xiy;
      w_xix4_nxt = r_xix4;
      if (w_p2) begin
         if (bus.P2_Set_XIX4_0 && r_xix) w_xix4_nxt = 1'b1;
         if (bus.P2_Set_XIY4_0 && r_xiy) w_xix4_nxt = 1'b1;
         if (bus.P2_Reset_XIX && r_xix) begin
            w_xix_nxt  = 1'b0;
            w_xix4_nxt = 1'b0;
         end
         if (bus.P2_Reset_XIY && r_xiy) begin
            w_xiy_nxt  = 1'b0;
            w_xix4_nxt = 1'b0;
         end
      end
      if (bus.Set_XIY) begin
         w_xiy_nxt = 1'b1;
         w_xix_nxt = 1'b0;
      end else if (bus.Set_XIX) begin
         w_xix_nxt = 1'b1;
         w_xiy_nxt = 1'b0;
      end
   end

   // State and registered outputs; everything holds while the bus stalls.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mode   <= MODE_M1;
         r_xix    <= 1'b0;
         r_xiy    <= 1'b0;
         r_xix4   <= 1'b0;
         r_armed  <= 1'b1;
         r_source <= '0;
         r_dec_en <= 1'b0;
      end else if (bus.Bus_Ready) begin
         r_mode   <= w_mode_nxt;
         r_xix    <= w_xix_nxt;
         r_xiy    <= w_xiy_nxt;
         r_xix4   <= w_xix4_nxt;
         if (w_fetch && r_armed)
            r_source <= bus.Bus_Data;
         r_armed  <= bus.Pa_Ophd | (r_armed & ~w_fetch);
         r_dec_en <= dec_enable_f(w_xix_nxt, w_xiy_nxt, w_xix4_nxt, w_mode_nxt);
      end
   end

   assign bus.Phase2     = w_phase2;
   assign bus.XPT        = w_xpt;
   assign bus.notXPT     = ~w_xpt;
   assign bus.Source     = r_source;
   assign bus.notSource  = ~r_source;
   assign bus.Dec_Enable = r_dec_en;
   assign bus.is_Y       = r_xiy;
   assign bus.In_XIX4    = r_xix4;
   assign bus.Mode       = r_mode;

endmodule

// File: tb/tb_sequencer_xix_timing.sv
// Directed scenarios plus randomized run against a cycle-level behavioural model.
module tb_sequencer_xix_timing;

   logic clock;
   logic reset;
   int   n_pass;
   int   n_total;

   // Behavioural model state
   int m_phase, m_xpt, m_mode, m_src, m_armed, m_xix, m_xiy, m_x4;

   sequencer_xix_timing_if u_if ();

   sequencer_xix_timing dut (
      .clock (clock),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One clock of the reference behaviour, using the inputs present at the edge.
   task automatic model_step();
      bit fetch_done;
      bit half2;
      if (reset) begin
         m_phase = 0; m_xpt = 0; m_mode = 0; m_src = 0;
         m_armed = 1; m_xix = 0; m_xiy = 0; m_x4 = 0;
         return;
      end
      if (!u_if.Bus_Ready) return;
      half2      = (m_phase == 1);
      fetch_done = half2 && (m_mode == 0) && (m_xpt == 1);
      if (fetch_done) begin
         if (m_armed == 1) m_src = int'(u_if.Bus_Data);
         m_armed = 0;
      end
      if (u_if.Pa_Ophd) m_armed = 1;
      if (half2) begin
         if (u_if.P2_Set_XIX4_0 && m_xix == 1) m_x4 = 1;
         if (u_if.P2_Set_XIY4_0 && m_xiy == 1) m_x4 = 1;
         if (u_if.P2_Reset_XIX && m_xix == 1) begin m_xix = 0; m_x4 = 0; end
         if (u_if.P2_Reset_XIY && m_xiy == 1) begin m_xiy = 0; m_x4 = 0; end
         if (m_mode != 0 && u_if.P2_Set_CM1) m_mode = 0;
         else if (m_mode == 2 && u_if.P2_Set_CMR) m_mode = 1;
      end
      if (fetch_done) m_mode = 2;
      if (u_if.Set_XIY)      begin m_xiy = 1; m_xix = 0; end
      else if (u_if.Set_XIX) begin m_xix = 1; m_xiy = 0; end
      if (u_if.PR_Reset_XPT) begin
         m_xpt = 0; m_phase = 0;
      end else begin
         if (half2 && m_xpt < 31) m_xpt = m_xpt + 1;
         m_phase = 1 - m_phase;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      u_if.Bus_Ready     = 1'b1;
      u_if.Bus_Data      = 8'h00;
      u_if.Set_XIX       = 1'b0;
      u_if.Set_XIY       = 1'b0;
      u_if.PR_Reset_XPT  = 1'b0;
      u_if.P2_Set_CM1    = 1'b0;
      u_if.P2_Set_CMR    = 1'b0;
      u_if.P2_Reset_XIX  = 1'b0;
      u_if.P2_Reset_XIY  = 1'b0;
      u_if.P2_Set_XIX4_0 = 1'b0;
      u_if.P2_Set_XIY4_0 = 1'b0;
      u_if.Pa_Ophd       = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] obs;
      apply_reset();
      obs = {u_if.Phase2, u_if.XPT, u_if.notXPT, u_if.Source, u_if.notSource,
             u_if.Dec_Enable, u_if.is_Y, u_if.In_XIX4, u_if.Mode};
      n_total++;
      if (obs !== {1'b0, 5'h00, 5'h1F, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd0})
         $display("FAIL reset_outputs: got %h expected %h", obs,
                  {1'b0, 5'h00, 5'h1F, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd0});
      else n_pass++;
   endtask

   task automatic test_count();
      apply_reset();
      for (int n = 1; n <= 8; n++) begin
         tick();
         n_total++;
         if (u_if.Phase2 !== 1'(n % 2) || u_if.XPT !== 5'(n / 2))
            $display("FAIL count_step%0d: got phase=%0d xpt=%0d expected phase=%0d xpt=%0d",
                     n, u_if.Phase2, u_if.XPT, n % 2, n / 2);
         else n_pass++;
         if (n <= 3) begin
            n_total++;
            if (u_if.Mode !== 2'd0)
               $display("FAIL count_mode%0d: got %0d expected 0", n, u_if.Mode);
            else n_pass++;
         end
      end
      n_total++;
      if (u_if.Source !== 8'h00)
         $display("FAIL count_source: got %h expected 00", u_if.Source);
      else n_pass++;
   endtask

   task automatic test_fetch();
      apply_reset();
      u_if.Set_XIX = 1'b1;
      tick();
      u_if.Set_XIX  = 1'b0;
      u_if.Bus_Data = 8'hE1;
      tick();
      tick();
      n_total++;
      if (u_if.Mode !== 2'd0 || u_if.Dec_Enable !== 1'b0)
         $display("FAIL fetch_pre: got mode=%0d dec=%0d expected mode=0 dec=0",
                  u_if.Mode, u_if.Dec_Enable);
      else n_pass++;
      tick();
      n_total++;
      if (u_if.Source !== 8'hE1 || u_if.notSource !== 8'h1E)
         $display("FAIL fetch_source: got %h/%h expected E1/1E", u_if.Source, u_if.notSource);
      else n_pass++;
      n_total++;
      if (u_if.Mode !== 2'd2 || u_if.Dec_Enable !== 1'b1 || u_if.is_Y !== 1'b0)
         $display("FAIL fetch_exec: got mode=%0d dec=%0d isy=%0d expected 2 1 0",
                  u_if.Mode, u_if.Dec_Enable, u_if.is_Y);
      else n_pass++;
   endtask

   // Continues from the EXEC state left by test_fetch.
   task automatic test_stall();
      u_if.Bus_Data = 8'h00;
      tick();
      u_if.Bus_Ready  = 1'b0;
      u_if.P2_Set_CM1 = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         n_total++;
         if (u_if.XPT !== 5'd2 || u_if.Phase2 !== 1'b1 || u_if.Mode !== 2'd2)
            $display("FAIL stall_hold%0d: got xpt=%0d phase=%0d mode=%0d expected 2 1 2",
                     n, u_if.XPT, u_if.Phase2, u_if.Mode);
         else n_pass++;
      end
      u_if.Bus_Ready  = 1'b1;
      u_if.P2_Set_CM1 = 1'b0;
      tick();
      n_total++;
      if (u_if.XPT !== 5'd3 || u_if.Phase2 !== 1'b0 || u_if.Mode !== 2'd2)
         $display("FAIL stall_resume: got xpt=%0d phase=%0d mode=%0d expected 3 0 2",
                  u_if.XPT, u_if.Phase2, u_if.Mode);
      else n_pass++;
   endtask

   task automatic test_xix4();
      apply_reset();
      u_if.Set_XIY = 1'b1;
      tick();
      u_if.Set_XIY       = 1'b0;
      u_if.P2_Set_XIX4_0 = 1'b1;
      tick();
      u_if.P2_Set_XIX4_0 = 1'b0;
      n_total++;
      if (u_if.In_XIX4 !== 1'b0 || u_if.is_Y !== 1'b1)
         $display("FAIL xix4_wrong_prefix: got x4=%0d isy=%0d expected 0 1", u_if.In_XIX4, u_if.is_Y);
      else n_pass++;
      tick();
      u_if.P2_Set_XIY4_0 = 1'b1;
      tick();
      u_if.P2_Set_XIY4_0 = 1'b0;
      n_total++;
      if (u_if.In_XIX4 !== 1'b1 || u_if.Dec_Enable !== 1'b0 || u_if.Mode !== 2'd2)
         $display("FAIL xiy4_set: got x4=%0d dec=%0d mode=%0d expected 1 0 2",
                  u_if.In_XIX4, u_if.Dec_Enable, u_if.Mode);
      else n_pass++;
      u_if.P2_Reset_XIY = 1'b1;
      tick();
      n_total++;
      if (u_if.is_Y !== 1'b1 || u_if.In_XIX4 !== 1'b1)
         $display("FAIL xiy_reset_phase1: got isy=%0d x4=%0d expected 1 1", u_if.is_Y, u_if.In_XIX4);
      else n_pass++;
      tick();
      u_if.P2_Reset_XIY = 1'b0;
      n_total++;
      if (u_if.is_Y !== 1'b0 || u_if.In_XIX4 !== 1'b0 || u_if.Dec_Enable !== 1'b0)
         $display("FAIL xiy_reset: got isy=%0d x4=%0d dec=%0d expected 0 0 0",
                  u_if.is_Y, u_if.In_XIX4, u_if.Dec_Enable);
      else n_pass++;
   endtask

   task automatic test_pr_reset();
      apply_reset();
      for (int n = 0; n < 15; n++) tick();
      n_total++;
      if (u_if.XPT !== 5'd7 || u_if.Phase2 !== 1'b1)
         $display("FAIL pr_setup: got xpt=%0d phase=%0d expected 7 1", u_if.XPT, u_if.Phase2);
      else n_pass++;
      u_if.PR_Reset_XPT = 1'b1;
      tick();
      u_if.PR_Reset_XPT = 1'b0;
      n_total++;
      if (u_if.XPT !== 5'd0 || u_if.Phase2 !== 1'b0)
         $display("FAIL pr_reset: got xpt=%0d phase=%0d expected 0 0", u_if.XPT, u_if.Phase2);
      else n_pass++;
      for (int n = 0; n < 70; n++) tick();
      n_total++;
      if (u_if.XPT !== 5'd31 || u_if.notXPT !== 5'd0 || u_if.Phase2 !== 1'b0)
         $display("FAIL xpt_saturate: got xpt=%0d nxpt=%0d phase=%0d expected 31 0 0",
                  u_if.XPT, u_if.notXPT, u_if.Phase2);
      else n_pass++;
   endtask

   task automatic test_both_prefix();
      logic [31:0] obs;
      apply_reset();
      u_if.Set_XIX  = 1'b1;
      u_if.Set_XIY  = 1'b1;
      u_if.Bus_Data = 8'h5A;
      tick();
      u_if.Set_XIX = 1'b0;
      u_if.Set_XIY = 1'b0;
      n_total++;
      if (u_if.is_Y !== 1'b1)
         $display("FAIL both_prefix: got isy=%0d expected 1", u_if.is_Y);
      else n_pass++;
      tick(); tick(); tick();
      n_total++;
      if (u_if.Mode !== 2'd2 || u_if.Dec_Enable !== 1'b1 || u_if.Source !== 8'h5A)
         $display("FAIL both_exec: got mode=%0d dec=%0d src=%h expected 2 1 5a",
                  u_if.Mode, u_if.Dec_Enable, u_if.Source);
      else n_pass++;
      u_if.Bus_Ready = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      u_if.Bus_Ready = 1'b1;
      obs = {u_if.Phase2, u_if.XPT, u_if.notXPT, u_if.Source, u_if.notSource,
             u_if.Dec_Enable, u_if.is_Y, u_if.In_XIX4, u_if.Mode};
      n_total++;
      if (obs !== {1'b0, 5'h00, 5'h1F, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd0})
         $display("FAIL reset_mid_exec: got %h expected %h", obs,
                  {1'b0, 5'h00, 5'h1F, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd0});
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] obs;
      logic [31:0] exp;
      apply_reset();
      for (int n = 0; n < 600; n++) begin
         reset              = ($urandom_range(99) < 2);
         u_if.Bus_Ready     = ($urandom_range(99) < 80);
         u_if.Bus_Data      = 8'($urandom);
         u_if.Set_XIX       = ($urandom_range(99) < 8);
         u_if.Set_XIY       = ($urandom_range(99) < 8);
         u_if.PR_Reset_XPT  = ($urandom_range(99) < 3);
         u_if.P2_Set_CM1    = ($urandom_range(99) < 10);
         u_if.P2_Set_CMR    = ($urandom_range(99) < 10);
         u_if.P2_Reset_XIX  = ($urandom_range(99) < 8);
         u_if.P2_Reset_XIY  = ($urandom_range(99) < 8);
         u_if.P2_Set_XIX4_0 = ($urandom_range(99) < 10);
         u_if.P2_Set_XIY4_0 = ($urandom_range(99) < 10);
         u_if.Pa_Ophd       = ($urandom_range(99) < 10);
         tick();
         exp = {1'(m_phase), 5'(m_xpt), ~5'(m_xpt), 8'(m_src), ~8'(m_src),
                1'((m_xix == 1 || m_xiy == 1) && m_x4 == 0 && m_mode == 2),
                1'(m_xiy), 1'(m_x4), 2'(m_mode)};
         obs = {u_if.Phase2, u_if.XPT, u_if.notXPT, u_if.Source, u_if.notSource,
                u_if.Dec_Enable, u_if.is_Y, u_if.In_XIX4, u_if.Mode};
         n_total++;
         if (obs !== exp)
            $display("FAIL random_cycle%0d: got %h expected %h", n, obs, exp);
         else n_pass++;
      end
      reset = 1'b0;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b1;
      idle_inputs();
      test_reset();
      test_count();
      test_fetch();
      test_stall();
      test_xix4();
      test_pr_reset();
      test_both_prefix();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sequencer_xix_timing.md
Name: sequencer_xix_timing

Overview:
- Consumer of the DD/FD (IX/IY) opcode decoder's control strobes.
- Holds the machine-step counter XPT, the index-prefix flags (XIX/XIY, XIX4/XIY4 for the DDCB/FDCB path), the cycle-mode state (M1 fetch / CMR operand read / execute) and the latched opcode Source.
- Feeds enable/is_Y/XPT/notXPT/Source/notSource back to the decoder.
- Sits between the bus interface unit and the decoder tree.

Parameters:
- XPT_W, 5, width of the step counter.
- XPT_MAX, 31, terminal step value; counter saturates here.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- Bus_Ready  in  1  bus cycle complete; low stalls step advance.
- Bus_Data  in  8  fetched byte.
- Set_XIX  in  1  DD prefix fetched (from main decoder).
- Set_XIY  in  1  FD prefix fetched.
- PR_Reset_XPT  in  1  restart step counter.
- P2_Set_CM1  in  1  next cycle is M1 fetch.
- P2_Set_CMR  in  1  next cycle is operand/displacement read.
- P2_Reset_XIX  in  1  clear IX prefix state.
- P2_Reset_XIY  in  1  clear IY prefix state.
- P2_Set_XIX4_0  in  1  enter DDCB sub-state.
- P2_Set_XIY4_0  in  1  enter FDCB sub-state.
- Pa_Ophd  in  1  arm opcode latch for next fetch.
- Phase2  out  1  high on second half of each step.
- XPT  out  5  current step.
- notXPT  out  5  bitwise inverse of XPT.
- Source  out  8  latched opcode.
- notSource  out  8  bitwise inverse of Source.
- Dec_Enable  out  1  XIX/XIY decoder enable.
- is_Y  out  1  IY (not IX) variant active.
- In_XIX4  out  1  DDCB/FDCB sub-state active.
- Mode  out  2  0=M1, 1=CMR, 2=EXEC.

Behaviour:
- Reset values:
  - Phase2=0, XPT=0, Source=0x00 (notSource=0xFF, notXPT=5'h1F).
  - Mode=M1, XIX=XIY=XIX4=0, Ophd_armed=1.
  - Dec_Enable=0, is_Y=0.
- Phase: toggles every clock while Bus_Ready=1. Holds while Bus_Ready=0; no strobe is applied while stalled.
- XPT: increments on the clock where Phase2=1 and Bus_Ready=1. Saturates at XPT_MAX (no wrap).
- PR_Reset_XPT: applied on any unstalled clock. Next XPT=0, Phase2=0; wins over increment.
- P2_* strobes: sampled only on unstalled clocks with Phase2=1; ignored otherwise.
- Mode state machine:
  - M1 --fetch done (Phase2 & Ready & XPT==1)--> EXEC; Source<=Bus_Data if Ophd_armed, then Ophd_armed<=0.
  - EXEC --P2_Set_CMR--> CMR.
  - EXEC/CMR --P2_Set_CM1--> M1.
  - CMR --P2_Set_CM1--> M1.
  - P2_Set_CM1 and P2_Set_CMR together: CM1 wins.
- Pa_Ophd: sets Ophd_armed=1 on any unstalled clock, effective for the next M1.
- Prefix flags:
  - Set_XIX sets XIX and clears XIY; Set_XIY sets XIY and clears XIX.
  - Both asserted together: XIY wins (last-prefix-wins, matching DD FD sequence semantics).
  - P2_Reset_XIX clears XIX and XIX4 when XIX=1; P2_Reset_XIY is the symmetric case.
  - Set and Reset of the same flag on one clock: Set wins.
- XIX4: P2_Set_XIX4_0 sets XIX4 (requires XIX=1); P2_Set_XIY4_0 likewise requires XIY=1. Ignored if the matching prefix flag is clear.
- Outputs:
  - is_Y = XIY.
  - Dec_Enable = (XIX|XIY) & ~XIX4 & Mode==EXEC.
  - In_XIX4 = XIX4.
  - All outputs registered except the not* inverses, which are combinational from registers.
- Reset mid-cycle: all state returns to reset values on the next clock regardless of Bus_Ready.

Decomposition:
- Shared package: Mode encodings (MODE_M1, MODE_CMR, MODE_EXEC), XPT_W, XPT_MAX.
- One natural sub-module: sequencer_step_counter (phase toggle + saturating XPT with stall and reset). Mode FSM and prefix flags stay in the top.

Test Plan:
1. Reset, Bus_Ready=1, no strobes → XPT 0,0,1,1,2,… (advances every 2 clocks), Phase2 alternates 0/1, Mode=M1, Source=0x00.
2. Set_XIX pulse, then M1 fetch with Bus_Data=0xE1 → at XPT==1 & Phase2: Source=0xE1, notSource=0x1E, Mode=EXEC, Dec_Enable=1, is_Y=0.
3. Bus_Ready=0 for 5 clocks mid-EXEC, with P2_Set_CM1 asserted during the stall → XPT, Phase2 and Mode frozen; strobe ignored; resumes from the same values when Ready returns.
4. Set_XIY, then P2_Set_XIX4_0 at Phase2 → In_XIX4 stays 0. P2_Set_XIY4_0 → In_XIX4=1, Dec_Enable=0. Then P2_Reset_XIY → XIY=0, In_XIX4=0.
5. PR_Reset_XPT together with an increment edge at XPT=7 → XPT=0, Phase2=0. With XPT held at 31 and no reset → remains 31.
6. Set_XIX and Set_XIY on the same clock → is_Y=1. Reset asserted mid-EXEC → all outputs at reset values on the next clock.
